// File: rtl/seg_reg_multi.sv
// Multi-lane pipeline stage register with stall, full/partial kill, optional
// deferral of flushes that arrive during a stall, and saturating statistics.
module seg_reg_multi #(
    parameter int LANES        = 2,
    parameter int WIDTH        = 32,
    parameter int CNT_W        = 16,
    parameter int STICKY_FLUSH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bubble,
    input  logic                   flush,
    input  logic [LANES-1:0]       kill_mask,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*32-1:0]    in_pc,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_predict,
    input  logic                   stat_clr,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*32-1:0]    out_pc,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_predict,
    output logic                   flush_pending,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             flush_pending_q, flush_pending_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             eff_flush;

    assign eff_flush = flush | flush_pending_q;

    // Each lane is an independent register slice sharing only bubble/flush.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic             valid_q, valid_d;
            logic [31:0]      pc_q, pc_d;
            logic [WIDTH-1:0] data_q, data_d;
            logic             predict_q, predict_d;

            always_comb begin
                valid_d   = valid_q;
                pc_d      = pc_q;
                data_d    = data_q;
                predict_d = predict_q;
                if (!bubble) begin
                    if (eff_flush || kill_mask[gi]) begin
                        valid_d   = 1'b0;
                        pc_d      = '0;
                        data_d    = '0;
                        predict_d = 1'b0;
                    end else begin
                        valid_d   = in_valid[gi];
                        pc_d      = in_pc[gi*32 +: 32];
                        data_d    = in_data[gi*WIDTH +: WIDTH];
                        predict_d = in_predict[gi];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q   <= 1'b0;
                    pc_q      <= '0;
                    data_q    <= '0;
                    predict_q <= 1'b0;
                end else begin
                    valid_q   <= valid_d;
                    pc_q      <= pc_d;
                    data_q    <= data_d;
                    predict_q <= predict_d;
                end
            end

            assign out_valid[gi]               = valid_q;
            assign out_pc[gi*32 +: 32]         = pc_q;
            assign out_data[gi*WIDTH +: WIDTH] = data_q;
            assign out_predict[gi]             = predict_q;
        end
    endgenerate

    // A stalled flush is remembered (sticky build) until the next moving edge,
    // where it is applied and retired.
    always_comb begin
        flush_pending_d = flush_pending_q;
        if (bubble) begin
            if (flush && (STICKY_FLUSH != 0)) begin
                flush_pending_d = 1'b1;
            end
        end else begin
            flush_pending_d = 1'b0;
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (!bubble && eff_flush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (stat_clr) begin
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pending_q <= 1'b0;
            bubble_cnt_q    <= '0;
            flush_cnt_q     <= '0;
        end else begin
            flush_pending_q <= flush_pending_d;
            bubble_cnt_q    <= bubble_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign flush_pending = flush_pending_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_seg_reg_multi.sv
// Bench for seg_reg_multi: a sticky 2-lane/CNT_W=4 instance and a dropping
// 3-lane/16-bit/CNT_W=5 instance share control inputs; a lane-array model predicts both.
module tb_seg_reg_multi;

    logic clk = 1'b0;
    logic rst, bubble, flush, stat_clr;
    always #5 clk = ~clk;

    // Instance A: LANES=2 WIDTH=32 CNT_W=4 STICKY=1
    logic [1:0]  ka, va, pa, ova, opa;
    logic [63:0] pca, da, opca, oda;
    logic        fpa;
    logic [3:0]  bca, fca;
    // Instance B: LANES=3 WIDTH=16 CNT_W=5 STICKY=0
    logic [2:0]  kb, vb, pb, ovb, opb;
    logic [95:0] pcb, opcb;
    logic [47:0] db, odb;
    logic        fpb;
    logic [4:0]  bcb, fcb;

    seg_reg_multi #(.LANES(2), .WIDTH(32), .CNT_W(4), .STICKY_FLUSH(1)) dut_a (
        .clk(clk), .rst(rst), .bubble(bubble), .flush(flush), .kill_mask(ka),
        .in_valid(va), .in_pc(pca), .in_data(da), .in_predict(pa), .stat_clr(stat_clr),
        .out_valid(ova), .out_pc(opca), .out_data(oda), .out_predict(opa),
        .flush_pending(fpa), .bubble_cnt(bca), .flush_cnt(fca)
    );

    seg_reg_multi #(.LANES(3), .WIDTH(16), .CNT_W(5), .STICKY_FLUSH(0)) dut_b (
        .clk(clk), .rst(rst), .bubble(bubble), .flush(flush), .kill_mask(kb),
        .in_valid(vb), .in_pc(pcb), .in_data(db), .in_predict(pb), .stat_clr(stat_clr),
        .out_valid(ovb), .out_pc(opcb), .out_data(odb), .out_predict(opb),
        .flush_pending(fpb), .bubble_cnt(bcb), .flush_cnt(fcb)
    );

    // Stimulus per instance/lane, packed onto the buses below.
    logic        i_valid [2][4];
    logic [31:0] i_pc    [2][4];
    logic [31:0] i_data  [2][4];
    logic        i_pred  [2][4];
    logic        i_kill  [2][4];

    always_comb begin
        ka = '0; va = '0; pa = '0; pca = '0; da = '0;
        kb = '0; vb = '0; pb = '0; pcb = '0; db = '0;
        for (int l = 0; l < 2; l++) begin
            ka[l] = i_kill[0][l]; va[l] = i_valid[0][l]; pa[l] = i_pred[0][l];
            pca[32*l +: 32] = i_pc[0][l]; da[32*l +: 32] = i_data[0][l];
        end
        for (int l = 0; l < 3; l++) begin
            kb[l] = i_kill[1][l]; vb[l] = i_valid[1][l]; pb[l] = i_pred[1][l];
            pcb[32*l +: 32] = i_pc[1][l]; db[16*l +: 16] = i_data[1][l][15:0];
        end
    end

    // Reference model state
    int          nl     [2] = '{2, 3};
    int          cmax   [2] = '{15, 31};
    bit          sticky [2] = '{1'b1, 1'b0};
    logic        m_valid [2][4];
    logic [31:0] m_pc    [2][4];
    logic [31:0] m_data  [2][4];
    logic        m_pred  [2][4];
    logic        m_pend  [2];
    int          m_bc    [2];
    int          m_fc    [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;

    task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 4; l++) begin
                m_valid[k][l] = 0; m_pc[k][l] = 0; m_data[k][l] = 0; m_pred[k][l] = 0;
            end
            m_pend[k] = 0; m_bc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit eff;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            eff = flush || m_pend[k];
            if (bubble) begin
                if (m_bc[k] < cmax[k]) m_bc[k]++;
                if (flush && sticky[k]) m_pend[k] = 1;
            end else begin
                for (int l = 0; l < nl[k]; l++) begin
                    if (eff || i_kill[k][l]) begin
                        m_valid[k][l] = 0; m_pc[k][l] = 0; m_data[k][l] = 0; m_pred[k][l] = 0;
                    end else begin
                        m_valid[k][l] = i_valid[k][l]; m_pc[k][l] = i_pc[k][l];
                        m_data[k][l] = i_data[k][l];   m_pred[k][l] = i_pred[k][l];
                    end
                end
                if (eff) begin
                    m_pend[k] = 0;
                    if (m_fc[k] < cmax[k]) m_fc[k]++;
                end
            end
            if (stat_clr) begin
                m_bc[k] = 0; m_fc[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [127:0] ev, epc, ed, ep;
        for (int k = 0; k < 2; k++) begin
            ev = '0; epc = '0; ed = '0; ep = '0;
            for (int l = 0; l < nl[k]; l++) begin
                ev[l] = m_valid[k][l];
                ep[l] = m_pred[k][l];
                epc[32*l +: 32] = m_pc[k][l];
                if (k == 0) ed[32*l +: 32] = m_data[k][l];
                else        ed[16*l +: 16] = m_data[k][l][15:0];
            end
            if (k == 0) begin
                expect_eq("A.valid", 128'(ova), ev);
                expect_eq("A.pc", 128'(opca), epc);
                expect_eq("A.data", 128'(oda), ed);
                expect_eq("A.predict", 128'(opa), ep);
                expect_eq("A.pending", 128'(fpa), 128'(m_pend[0]));
                expect_eq("A.bubble_cnt", 128'(bca), 128'(m_bc[0]));
                expect_eq("A.flush_cnt", 128'(fca), 128'(m_fc[0]));
            end else begin
                expect_eq("B.valid", 128'(ovb), ev);
                expect_eq("B.pc", 128'(opcb), epc);
                expect_eq("B.data", 128'(odb), ed);
                expect_eq("B.predict", 128'(opb), ep);
                expect_eq("B.pending", 128'(fpb), 128'(m_pend[1]));
                expect_eq("B.bubble_cnt", 128'(bcb), 128'(m_bc[1]));
                expect_eq("B.flush_cnt", 128'(fcb), 128'(m_fc[1]));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        $display("cyc %0d rst=%b bub=%b fl=%b clr=%b A:v=%b pc=%h pend=%b bc=%0d fc=%0d B:v=%b pend=%b bc=%0d fc=%0d",
                 cyc, rst, bubble, flush, stat_clr, ova, opca, fpa, bca, fca, ovb, fpb, bcb, fcb);
        check_all();
    endtask

    task automatic set_lane(input int k, input int l, input logic v, input logic [31:0] pc,
                            input logic [31:0] d, input logic p, input logic kill);
        i_valid[k][l] = v; i_pc[k][l] = pc; i_pred[k][l] = p; i_kill[k][l] = kill;
        i_data[k][l] = (k == 0) ? d : (d & 32'h0000_FFFF);
    endtask

    task automatic load_basic(input logic [1:0] kill_a);
        set_lane(0, 0, 1'b1, 32'h100, 32'hDEAD_0000, 1'b0, kill_a[0]);
        set_lane(0, 1, 1'b1, 32'h104, 32'hBEEF_0001, 1'b1, kill_a[1]);
        set_lane(1, 0, 1'b1, 32'h100, 32'h1111, 1'b0, kill_a[0]);
        set_lane(1, 1, 1'b1, 32'h104, 32'h2222, 1'b1, kill_a[1]);
        set_lane(1, 2, 1'b1, 32'h108, 32'h3333, 1'b1, 1'b0);
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < 2; k++)
            for (int l = 0; l < 4; l++)
                set_lane(k, l, 1'($urandom), $urandom, $urandom, 1'($urandom),
                         ($urandom_range(0, 5) == 0));
        bubble   = ($urandom_range(0, 9) < 3);
        flush    = ($urandom_range(0, 19) < 3);
        stat_clr = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        rst = 1'b1; bubble = 0; flush = 0; stat_clr = 0;
        for (int k = 0; k < 2; k++)
            for (int l = 0; l < 4; l++) set_lane(k, l, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Plain load on both instances
        load_basic(2'b00);
        step();
        expect_eq("load.pc", 128'(opca), 128'(64'h0000_0104_0000_0100));
        expect_eq("load.predict", 128'(opa), 128'(2'b10));

        // Partial kill of lane 1
        load_basic(2'b10);
        step();
        expect_eq("kill.valid", 128'(ova), 128'(2'b01));
        expect_eq("kill.flush_cnt", 128'(fca), 128'(0));

        // Flush during a stall: deferred on A, dropped on B
        load_basic(2'b00);
        step();
        bubble = 1; flush = 1;
        step();
        expect_eq("defer.pending", 128'(fpa), 128'(1));
        expect_eq("defer.held_valid", 128'(ova), 128'(2'b11));
        bubble = 0; flush = 0;
        step();
        expect_eq("defer.applied_valid", 128'(ova), 128'(0));
        expect_eq("defer.flush_cnt", 128'(fca), 128'(1));
        expect_eq("defer.bubble_cnt", 128'(bca), 128'(1));
        expect_eq("drop.valid", 128'(ovb), 128'(3'b111));
        expect_eq("drop.flush_cnt", 128'(fcb), 128'(0));

        // Kill mask ignored during a stall
        load_basic(2'b11);
        bubble = 1;
        step();

        // Counter saturation then clear while stalled
        for (int i = 0; i < 20; i++) step();
        expect_eq("sat.bubble_cnt", 128'(bca), 128'(15));
        stat_clr = 1;
        step();
        expect_eq("clr.bubble_cnt", 128'(bca), 128'(0));
        stat_clr = 0; bubble = 0;
        load_basic(2'b00);
        step();

        // Asynchronous reset between edges, held across an edge, then released
        #2 rst = 1'b1;
        model_reset();
        #1;
        expect_eq("arst.valid_now", 128'(ova), 128'(0));
        check_all();
        bubble = 1; flush = 1; stat_clr = 1;
        step();
        #2 rst = 1'b0;
        bubble = 0; flush = 0; stat_clr = 0;
        load_basic(2'b00);
        step();
        expect_eq("arst.first_load", 128'(ova), 128'(2'b11));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_reg_multi.md
SEG_REG_MULTI -- requirements
Module: seg_reg_multi

Interface
REQ-001 SHALL have parameter LANES, default 2: number of parallel instruction lanes (1..4).
REQ-002 SHALL have parameter WIDTH, default 32: per-lane payload width in bits.
REQ-003 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-004 SHALL have parameter STICKY_FLUSH, default 1.
  - 1: a flush seen during bubble is deferred.
  - 0: a flush seen during bubble is dropped.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port bubble, input, 1: stall; hold all stage state.
REQ-008 SHALL have port flush, input, 1: kill all lanes.
REQ-009 SHALL have port kill_mask, input, LANES: per-lane partial kill; bit i kills lane i.
REQ-010 SHALL have port in_valid, input, LANES: per-lane valid from the previous stage.
REQ-011 SHALL have port in_pc, input, LANES*32: per-lane PC; lane i is bits [32i+31:32i].
REQ-012 SHALL have port in_data, input, LANES*WIDTH: per-lane payload; same lane packing as in_pc.
REQ-013 SHALL have port in_predict, input, LANES: per-lane branch-prediction bit.
REQ-014 SHALL have port stat_clr, input, 1: synchronous clear of both counters.
REQ-015 SHALL have ports out_valid (LANES), out_pc (LANES*32), out_data (LANES*WIDTH), out_predict (LANES), all outputs: registered stage contents.
REQ-016 SHALL have port flush_pending, output, 1: a deferred flush is waiting.
REQ-017 SHALL have ports bubble_cnt and flush_cnt, outputs, CNT_W each: stall-cycle count and applied-flush count.

Function
REQ-018 Effective flush SHALL be: eff_flush = flush OR flush_pending.
REQ-019 On each posedge with bubble=1, every out_* register SHALL hold its value, regardless of flush or kill_mask.
REQ-020 With bubble=1, flush=1 and STICKY_FLUSH=1, flush_pending SHALL set to 1 on that edge.
REQ-021 With bubble=1, flush=1 and STICKY_FLUSH=0, the flush SHALL be discarded and flush_pending SHALL stay 0.
REQ-022 With bubble=0 and eff_flush=1, every lane SHALL load out_valid=0, out_pc=0, out_data=0 and out_predict=0; flush_pending SHALL clear.
REQ-023 With bubble=0, eff_flush=0 and kill_mask[i]=1, lane i SHALL load all-zero contents (including valid=0); every other lane loads normally.
REQ-024 With bubble=0, eff_flush=0 and kill_mask[i]=0, lane i SHALL load in_valid[i], in_pc, in_data and in_predict unchanged.
REQ-025 Latency SHALL be exactly one cycle from input to output; there is no combinational path from inputs to out_*.
REQ-026 kill_mask SHALL be ignored while bubble=1; it is not deferred.
REQ-027 bubble_cnt SHALL increment on every posedge with bubble=1 and saturate at 2^CNT_W-1.
REQ-028 flush_cnt SHALL increment once per applied flush (REQ-022 case), including deferred flushes, and saturate at 2^CNT_W-1.
  - Partial kills SHALL NOT count.
REQ-029 stat_clr=1 SHALL zero both counters on that edge, overriding any increment in the same cycle.
  - stat_clr SHALL have no effect on datapath state or flush_pending.
REQ-030 Lanes SHALL be fully independent except for the shared bubble and flush controls.

Reset
REQ-031 While rst=1, all out_*, flush_pending, bubble_cnt and flush_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 Reset SHALL dominate bubble, flush and stat_clr.
REQ-033 Reset deassertion mid-operation SHALL give an empty stage (all valid=0).
  - The first non-bubble edge after deassertion SHALL load normally.

Verification
REQ-034 Load: LANES=2, in_valid=2'b11, lane0 pc=0x100, lane1 pc=0x104, in_predict=2'b10 -> next cycle out_valid=2'b11, out_pc={0x104,0x100}, out_predict=2'b10.
REQ-035 Partial kill: kill_mask=2'b10 with the REQ-034 inputs -> out_valid=2'b01, lane1 out_pc=0, lane0 out_pc=0x100; flush_cnt unchanged.
REQ-036 Deferred flush, STICKY_FLUSH=1: bubble=1 and flush=1 for one cycle, then bubble=0 and flush=0 -> outputs held during the bubble cycle, flush_pending=1, then all lanes zero next edge, flush_pending=0, flush_cnt=1, bubble_cnt=1.
REQ-037 Dropped flush, STICKY_FLUSH=0: same stimulus as REQ-036 -> flush_pending stays 0; after the bubble the stage loads inputs; flush_cnt=0.
REQ-038 Saturation/clear: CNT_W=4, bubble=1 for 20 cycles -> bubble_cnt=15; then stat_clr=1 with bubble=1 -> bubble_cnt=0.
REQ-039 Async reset: assert rst between clock edges with valid data loaded -> all outputs 0 before the next posedge; after release, the first load occurs normally.
